avl_pattern_rw_tester: RTL and testbench
========================================

Name: avl_pattern_rw_tester

Overview:
Parametrised successor to the single-word LPDDR2 fill tester. Fills a frame-sized region of DDR through the Avalon-MM port using fixed-length bursts and one of four selectable data patterns. Optionally reads the region back and compares each word against the expected pattern. Used for bring-up of the frame buffer ahead of the HDMI path and for board self-test; reports done, pass/fail, error count and first failing address.

Parameters:
ADDR_W, 27, Avalon word-address width
DATA_W, 32, Avalon data width
BURST_W, 4, avl_burstcount width
BURST_LEN, 8, beats per burst; 1..2^(BURST_W-1); must divide NUM_WORDS
NUM_WORDS, 2073600, words in test region (default 1920*1080)
BASE_ADDR, 0, first word address of region
ERR_W, 16, error counter width

Ports:
iCLK  in  1  sole clock; all logic rising-edge
iRST  in  1  synchronous, active-high reset
iSTART  in  1  start request; rising edge detected internally
iMODE  in  2  pattern select; latched at start
iVERIFY  in  1  1 = read-back/compare after fill; latched at start
iFILL  in  DATA_W  constant for mode 1; latched at start
local_init_done  in  1  DDR controller calibrated
avl_waitrequest_n  in  1  slave ready; a beat/command transfers when high
avl_address  out  ADDR_W  burst start word address
avl_writedata  out  DATA_W  write beat data
avl_write  out  1  write request
avl_read  out  1  read command
avl_burstbegin  out  1  first write beat / read command qualifier
avl_burstcount  out  BURST_W  constant BURST_LEN
avl_readdata  in  DATA_W  read data
avl_readdatavalid  in  1  read beat valid
oBUSY  out  1  test running
oDONE  out  1  test complete; held until next start or reset
oPASS  out  1  valid with oDONE; 1 if zero mismatches (always 1 when iVERIFY=0)
oERR_COUNT  out  ERR_W  mismatch count, saturating
oFIRST_ERR_ADDR  out  ADDR_W  word address of first mismatch; 0 if none
c_state  out  4  state encoding, for SignalTap

Behaviour:
- Reset: all outputs 0, except avl_burstcount (constant BURST_LEN); state IDLE; start edge detector primed so an iSTART held high through reset does not trigger.
- Start = iSTART rising edge (registered 2-flop detect). Honoured only in IDLE or DONE, and only with local_init_done=1; otherwise ignored. Start clears oDONE, oPASS, oERR_COUNT and oFIRST_ERR_ADDR.
- Word index i = avl_address - BASE_ADDR + beat number. Pattern:
  - Mode 0: i zero-extended/truncated to DATA_W.
  - Mode 1: iFILL.
  - Mode 2: quarter bars: i<N/4 -> 00FF0000; <N/2 -> 0000FF00; <3N/4 -> 000000FF; else 00FFFFFF (N = NUM_WORDS, integer division).
  - Mode 3: i even -> 00FF0000; i odd -> 000FFFFF.
- States (c_state):
  - IDLE(0): start -> WR_BURST.
  - WR_BURST(1): avl_write=1; avl_burstbegin=1 on first beat only; data for beat k. Beat advances only when avl_waitrequest_n=1. All outputs held stable while it is 0. After beat BURST_LEN-1 transfers: if the last burst is done -> RD_CMD (iVERIFY latched 1) or DONE; else advance address by BURST_LEN and start the next burst the following cycle. No idle cycle is required between bursts.
  - RD_CMD(4): avl_read=1 and avl_burstbegin=1 for one accepted cycle, held until avl_waitrequest_n=1 -> RD_DATA.
  - RD_DATA(5): count BURST_LEN avl_readdatavalid beats. Compare each against the pattern. On mismatch, increment oERR_COUNT (saturate at all-ones). On the first mismatch, capture the word address. After the last beat: next burst -> RD_CMD, else DONE. Only one read burst is outstanding at a time.
  - DONE(9): oDONE=1, oBUSY=0; wait for start.
- oBUSY=1 in every state except IDLE and DONE.
- avl_write and avl_read are never high together.
- avl_readdatavalid outside RD_DATA is ignored.
- Reset mid-burst: the next cycle shows reset values. Write is dropped; the controller tolerates a truncated burst.
- Address arithmetic is modulo 2^ADDR_W.

Test Plan:
1. NUM_WORDS=16, BURST_LEN=4, mode 0, iVERIFY=0, waitrequest_n=1 -> bursts at 0,4,8,12. writedata 0..15, burstbegin on beats 0 only, 16 write cycles. Then oDONE=1, oPASS=1, oERR_COUNT=0.
2. Same config with waitrequest_n low for 3 cycles on beats 2 and 9 -> data/address held, no beat lost or duplicated, memory model holds 0..15.
3. Mode 0, iVERIFY=1, memory model corrupts word 6 -> oERR_COUNT=1, oFIRST_ERR_ADDR=BASE_ADDR+6, oPASS=0. A clean model gives oPASS=1.
4. Mode 2, NUM_WORDS=16 -> words 0-3 00FF0000, 4-7 0000FF00, 8-11 000000FF, 12-15 00FFFFFF. Mode 3 -> alternating 00FF0000/000FFFFF. Mode 1 with iFILL=DEADBEEF -> all DEADBEEF.
5. Start with local_init_done=0 -> stays IDLE. Start pulse while busy -> ignored. Start in DONE -> status cleared, rerun.
6. iRST=1 mid-write burst -> avl_write=0, oBUSY=0, c_state=0 next cycle. iSTART held high across reset -> no start.

Source files
------------

// File: rtl/avl_pattern_rw_tester.sv
// Fills a DDR region over Avalon-MM with fixed-length write bursts of a selectable pattern,
// then optionally reads it back and reports mismatch count and first failing address.
module avl_pattern_rw_tester #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 4,
  parameter int BURST_LEN = 8,
  parameter int NUM_WORDS = 2073600,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [1:0]        iMODE,
  input  logic              iVERIFY,
  input  logic [DATA_W-1:0] iFILL,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_write,
  output logic              avl_read,
  output logic              avl_burstbegin,
  output logic [BURST_W-1:0] avl_burstcount,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oPASS,
  output logic [ERR_W-1:0]  oERR_COUNT,
  output logic [ADDR_W-1:0] oFIRST_ERR_ADDR,
  output logic [3:0]        c_state
);

  // Handshake: a write beat or read command transfers on a rising edge where the
  // request is high and avl_waitrequest_n is high; all request outputs hold otherwise.
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_BURST = 4'd1;
  localparam logic [3:0] RD_CMD   = 4'd4;
  localparam logic [3:0] RD_DATA  = 4'd5;
  localparam logic [3:0] DONE     = 4'd9;

  localparam logic [BURST_W-1:0] LAST_BEAT  = BURST_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0]  LAST_BURST = ADDR_W'(NUM_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0]  STEP       = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  Q1         = ADDR_W'(NUM_WORDS / 4);
  localparam logic [ADDR_W-1:0]  Q2         = ADDR_W'(NUM_WORDS / 2);
  localparam logic [ADDR_W-1:0]  Q3         = ADDR_W'((3 * NUM_WORDS) / 4);
  localparam logic [DATA_W-1:0]  C_RED      = DATA_W'(32'h00FF0000);
  localparam logic [DATA_W-1:0]  C_GREEN    = DATA_W'(32'h0000FF00);
  localparam logic [DATA_W-1:0]  C_BLUE     = DATA_W'(32'h000000FF);
  localparam logic [DATA_W-1:0]  C_WHITE    = DATA_W'(32'h00FFFFFF);
  localparam logic [DATA_W-1:0]  C_ODD      = DATA_W'(32'h000FFFFF);

  logic [3:0]         state;
  logic               start_d1, start_d2, start_pulse;
  logic [1:0]         mode_r;
  logic               verify_r;
  logic [DATA_W-1:0]  fill_r;
  logic [ADDR_W-1:0]  burst_idx;
  logic [BURST_W-1:0] beat;
  logic [ADDR_W-1:0]  word_idx;
  logic [DATA_W-1:0]  cur_pat;
  logic               done_r;
  logic [ERR_W-1:0]   err_cnt;
  logic [ADDR_W-1:0]  first_err;
  logic               last_beat, last_burst;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] i,
                                                input logic [DATA_W-1:0] fill);
    case (m)
      2'd0:    return DATA_W'(i);
      2'd1:    return fill;
      2'd2:    return (i < Q1) ? C_RED : (i < Q2) ? C_GREEN : (i < Q3) ? C_BLUE : C_WHITE;
      default: return i[0] ? C_ODD : C_RED;
    endcase
  endfunction

  assign start_pulse = start_d1 & ~start_d2;
  assign word_idx    = burst_idx + ADDR_W'(beat);
  assign cur_pat     = pattern(mode_r, word_idx, fill_r);
  assign last_beat   = (beat == LAST_BEAT);
  assign last_burst  = (burst_idx == LAST_BURST);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      // Edge detector primed high so a start held through reset is not seen as an edge.
      start_d1  <= 1'b1;
      start_d2  <= 1'b1;
      state     <= IDLE;
      mode_r    <= '0;
      verify_r  <= 1'b0;
      fill_r    <= '0;
      burst_idx <= '0;
      beat      <= '0;
      done_r    <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      start_d1 <= iSTART;
      start_d2 <= start_d1;
      case (state)
        IDLE, DONE: begin
          if (start_pulse && local_init_done) begin
            state     <= WR_BURST;
            mode_r    <= iMODE;
            verify_r  <= iVERIFY;
            fill_r    <= iFILL;
            burst_idx <= '0;
            beat      <= '0;
            done_r    <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
          end
        end
        WR_BURST: begin
          if (avl_waitrequest_n) begin
            if (!last_beat) begin
              beat <= beat + 1'b1;
            end else begin
              beat <= '0;
              if (!last_burst) begin
                burst_idx <= burst_idx + STEP;
              end else if (verify_r) begin
                burst_idx <= '0;
                state     <= RD_CMD;
              end else begin
                state  <= DONE;
                done_r <= 1'b1;
              end
            end
          end
        end
        RD_CMD: begin
          if (avl_waitrequest_n) begin
            beat  <= '0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (avl_readdatavalid) begin
            if (avl_readdata != cur_pat) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              if (err_cnt == '0) first_err <= BASE + word_idx;
            end
            if (!last_beat) begin
              beat <= beat + 1'b1;
            end else begin
              beat <= '0;
              if (!last_burst) begin
                burst_idx <= burst_idx + STEP;
                state     <= RD_CMD;
              end else begin
                state  <= DONE;
                done_r <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign avl_write       = (state == WR_BURST);
  assign avl_read        = (state == RD_CMD);
  assign avl_burstbegin  = (avl_write && beat == '0) || avl_read;
  assign avl_address     = (avl_write || avl_read) ? BASE + burst_idx : '0;
  assign avl_writedata   = avl_write ? cur_pat : '0;
  assign avl_burstcount  = BURST_W'(BURST_LEN);
  assign oBUSY           = (state != IDLE) && (state != DONE);
  assign oDONE           = done_r;
  assign oPASS           = done_r && (err_cnt == '0);
  assign oERR_COUNT      = err_cnt;
  assign oFIRST_ERR_ADDR = first_err;
  assign c_state         = state;

endmodule

// File: tb/tb_avl_pattern_rw_tester.sv
// Bench for avl_pattern_rw_tester: randomized Avalon slave with memory model,
// spec-level pattern model, per-cycle invariant monitor and end-of-run status checks.
module tb_avl_pattern_rw_tester;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BURST_W = 4;
  localparam int BL = 4;
  localparam int NW = 16;
  localparam int BASE = 'h40;
  localparam int ERR_W = 8;

  logic              clk = 1'b0;
  logic              iRST, iSTART, iVERIFY, local_init_done;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] iFILL;
  logic              avl_waitrequest_n;
  logic [ADDR_W-1:0] avl_address;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_write, avl_read, avl_burstbegin;
  logic [BURST_W-1:0] avl_burstcount;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;
  logic              oBUSY, oDONE, oPASS;
  logic [ERR_W-1:0]  oERR_COUNT;
  logic [ADDR_W-1:0] oFIRST_ERR_ADDR;
  logic [3:0]        c_state;

  avl_pattern_rw_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .BURST_LEN(BL),
    .NUM_WORDS(NW), .BASE_ADDR(BASE), .ERR_W(ERR_W)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iMODE(iMODE), .iVERIFY(iVERIFY),
    .iFILL(iFILL), .local_init_done(local_init_done),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
    .avl_writedata(avl_writedata), .avl_write(avl_write), .avl_read(avl_read),
    .avl_burstbegin(avl_burstbegin), .avl_burstcount(avl_burstcount),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .oBUSY(oBUSY), .oDONE(oDONE), .oPASS(oPASS), .oERR_COUNT(oERR_COUNT),
    .oFIRST_ERR_ADDR(oFIRST_ERR_ADDR), .c_state(c_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] exp_word(input int mode, input logic [31:0] fill, input int i);
    case (mode)
      0: return 32'(i);
      1: return fill;
      2: begin
        if (i < NW / 4) return 32'h00FF0000;
        else if (i < NW / 2) return 32'h0000FF00;
        else if (i < (3 * NW) / 4) return 32'h000000FF;
        else return 32'h00FFFFFF;
      end
      default: return (i % 2 == 0) ? 32'h00FF0000 : 32'h000FFFFF;
    endcase
  endfunction

  logic [31:0] mem [NW];
  int          rd_q[$];
  int          cur_mode = 0;
  logic [31:0] cur_fill = '0;
  int          corrupt = -1;
  int          wmode = 0;
  bit          chk_en = 0;
  bit          mon_en = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          rd_bursts = 0;

  // ---------------- Avalon slave + write/read sequence checks ----------------
  initial begin
    bit          prev_stall = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        prev_bb = 1'b0;
    int          stall_n = 0;
    bit          wr_n;
    int          idx;
    avl_waitrequest_n = 1'b1;
    avl_readdatavalid = 1'b0;
    avl_readdata = '0;
    forever begin
      @(negedge clk);
      if (iRST) begin
        rd_q.delete();
        avl_readdatavalid = 1'b0;
        avl_waitrequest_n = 1'b1;
        prev_stall = 0;
        stall_n = 0;
      end else begin
        if (prev_stall && chk_en) begin
          check("hold_write", avl_write, 1);
          check("hold_addr", avl_address, prev_addr);
          check("hold_data", avl_writedata, prev_data);
          check("hold_bb", avl_burstbegin, prev_bb);
        end
        if (rd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = rd_q.pop_front();
          avl_readdata = (idx == corrupt) ? ~mem[idx] : mem[idx];
          avl_readdatavalid = 1'b1;
          rd_count++;
        end else if (avl_write && $urandom_range(0, 3) == 0) begin
          avl_readdata = $urandom;
          avl_readdatavalid = 1'b1;
        end else begin
          avl_readdatavalid = 1'b0;
        end
        case (wmode)
          0: wr_n = 1'b1;
          1: wr_n = ($urandom_range(0, 3) != 0);
          default: begin
            if (avl_write && (wr_count == 2 || wr_count == 9) && stall_n < 3) begin
              wr_n = 1'b0;
              stall_n++;
            end else begin
              wr_n = 1'b1;
            end
          end
        endcase
        avl_waitrequest_n = wr_n;
        prev_stall = avl_write && !wr_n;
        prev_addr = avl_address;
        prev_data = avl_writedata;
        prev_bb = avl_burstbegin;
        if (chk_en && avl_write && wr_n) begin
          stall_n = 0;
          if (wr_count >= NW) begin
            check("extra_write", 64'(wr_count), 64'(NW - 1));
          end else begin
            check("wr_addr", avl_address, 64'(BASE + (wr_count / BL) * BL));
            check("wr_data", avl_writedata, exp_word(cur_mode, cur_fill, wr_count));
            check("wr_bb", avl_burstbegin, (wr_count % BL) == 0);
            mem[wr_count] = avl_writedata;
          end
          wr_count++;
        end
        if (chk_en && avl_read && wr_n) begin
          check("one_outstanding", 64'(rd_q.size()), 0);
          check("rd_addr", avl_address, 64'(BASE + rd_bursts * BL));
          check("rd_bb", avl_burstbegin, 1);
          for (int k = 0; k < BL; k++) rd_q.push_back(rd_bursts * BL + k);
          rd_bursts++;
        end
      end
    end
  end

  // ---------------- per-cycle invariant monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !iRST) begin
        check("wr_rd_excl", avl_write & avl_read, 0);
        check("busy_state", oBUSY, !(c_state == 4'd0 || c_state == 4'd9));
        check("done_state", oDONE, c_state == 4'd9);
        check("burstcount", avl_burstcount, BL);
        check("pass_qual", oPASS & ~oDONE, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    iSTART = 1'b1;
    repeat (3) @(negedge clk);
    iSTART = 1'b0;
  endtask

  task automatic run(input int mode, input bit verify, input logic [31:0] fill,
                     input int corr, input int wm, input bit busy_pulse);
    int t;
    int exp_err;
    cur_mode = mode;
    cur_fill = fill;
    corrupt = corr;
    wmode = wm;
    wr_count = 0;
    rd_count = 0;
    rd_bursts = 0;
    chk_en = 1;
    iMODE = mode[1:0];
    iVERIFY = verify;
    iFILL = fill;
    pulse_start();
    check("start_busy", oBUSY, 1);
    check("start_clr_done", oDONE, 0);
    check("start_clr_err", oERR_COUNT, 0);
    check("start_clr_first", oFIRST_ERR_ADDR, 0);
    iMODE = 2'($urandom);
    iVERIFY = 1'($urandom);
    iFILL = $urandom;
    if (busy_pulse) begin
      @(negedge clk);
      pulse_start();
    end
    t = 0;
    while (!oDONE && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", oDONE, 1);
    exp_err = (verify && corr >= 0) ? 1 : 0;
    check("wr_count", 64'(wr_count), 64'(NW));
    check("rd_count", 64'(rd_count), verify ? 64'(NW) : 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 0);
    check("busy_end", oBUSY, 0);
    check("err_count", oERR_COUNT, 64'(exp_err));
    check("pass", oPASS, exp_err == 0);
    check("first_err", oFIRST_ERR_ADDR, exp_err != 0 ? 64'(BASE + corr) : 64'd0);
    for (int i = 0; i < NW; i++) check("mem", mem[i], exp_word(mode, fill, i));
    chk_en = 0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    iRST = 1'b1;
    iSTART = 1'b0;
    iMODE = '0;
    iVERIFY = 1'b0;
    iFILL = '0;
    local_init_done = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_write", avl_write, 0);
    check("rst_read", avl_read, 0);
    check("rst_bb", avl_burstbegin, 0);
    check("rst_addr", avl_address, 0);
    check("rst_wdata", avl_writedata, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_done", oDONE, 0);
    check("rst_pass", oPASS, 0);
    check("rst_err", oERR_COUNT, 0);
    check("rst_first", oFIRST_ERR_ADDR, 0);
    check("rst_state", c_state, 0);
    check("rst_bcount", avl_burstcount, BL);
    iRST = 1'b0;
    mon_en = 1;
    @(negedge clk);

    run(0, 0, '0, -1, 0, 0);
    check("pin_m0", mem[13], 32'd13);
    run(0, 0, '0, -1, 2, 0);
    run(0, 1, '0, 6, 1, 0);
    run(0, 1, '0, -1, 1, 0);
    run(2, 1, '0, -1, 1, 0);
    check("pin_m2_a", mem[0], 32'h00FF0000);
    check("pin_m2_b", mem[5], 32'h0000FF00);
    check("pin_m2_c", mem[10], 32'h000000FF);
    check("pin_m2_d", mem[15], 32'h00FFFFFF);
    run(3, 1, '0, 3, 1, 0);
    check("pin_m3_a", mem[2], 32'h00FF0000);
    check("pin_m3_b", mem[7], 32'h000FFFFF);
    run(1, 1, 32'hDEADBEEF, -1, 1, 0);
    check("pin_m1", mem[9], 32'hDEADBEEF);
    for (int r = 0; r < 6; r++) begin
      run(int'($urandom_range(0, 3)), 1'($urandom), $urandom,
          ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, NW - 1)) : -1,
          int'($urandom_range(0, 2)), 0);
    end
    run(0, 1, '0, -1, 1, 1);

    // start ignored without calibration
    local_init_done = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    check("no_init_state", c_state, 9);
    check("no_init_busy", oBUSY, 0);
    local_init_done = 1'b1;
    repeat (5) @(negedge clk);
    check("no_init_late", c_state, 9);

    // reset mid-burst, start held high across reset
    cur_mode = 0;
    corrupt = -1;
    wmode = 1;
    wr_count = 0;
    chk_en = 1;
    iMODE = 2'd0;
    iVERIFY = 1'b0;
    pulse_start();
    t = 0;
    while (wr_count < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_burst_reached", 64'(wr_count >= 5), 1);
    check("mid_burst_writing", avl_write, 1);
    chk_en = 0;
    iSTART = 1'b1;
    iRST = 1'b1;
    @(negedge clk);
    check("rst_mid_write", avl_write, 0);
    check("rst_mid_busy", oBUSY, 0);
    check("rst_mid_state", c_state, 0);
    check("rst_mid_addr", avl_address, 0);
    repeat (2) @(negedge clk);
    iRST = 1'b0;
    repeat (8) @(negedge clk);
    check("held_start_state", c_state, 0);
    check("held_start_busy", oBUSY, 0);
    iSTART = 1'b0;
    @(negedge clk);
    run(3, 1, '0, 15, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
